// File: rtl/arb_mux_reg_pkg.sv
// Shared definitions for the arbitrating multiplexer: arbitration mode
// constants and the index-width helper.
package arb_mux_reg_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Bits needed to encode indices 0..n-1, never less than one bit so that
    // a single-channel instance still has a usable select field.
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/arb_mux_reg_if.sv
// Channel-side and consumer-side bundle of the arbitrating multiplexer.
// The master modport is the arbiter's view; slave is the environment's view.
interface arb_mux_reg_if
    import arb_mux_reg_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int SEL_W = clog2_min1(N);

    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SEL_W-1:0] out_sel;
    logic             out_ready;
    logic             lock;

    modport master (
        input  in_valid, in_data, out_ready, lock,
        output in_ready, out_valid, out_data, out_sel
    );

    modport slave (
        output in_valid, in_data, out_ready, lock,
        input  in_ready, out_valid, out_data, out_sel
    );

endinterface

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Combinational arbiter: scans the request vector upward from a start index
// (the rr pointer in round-robin mode, 0 in fixed-priority mode), wrapping
// from N-1 to 0, and returns a one-hot grant plus the encoded winner.
module rr_arbiter
    import arb_mux_reg_pkg::*;
#(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     req_i,
    input  logic [SEL_W-1:0] ptr_i,
    input  logic             mode_rr_i,
    output logic [N-1:0]     grant_o,
    output logic [SEL_W-1:0] winner_o,
    output logic             any_o
);

    // Priority search starting at the selected origin; first hit wins.
    always_comb begin
        int start_idx;
        int idx;
        any_o     = 1'b0;
        winner_o  = '0;
        start_idx = mode_rr_i ? int'(ptr_i) : 0;
        if (start_idx >= N) begin
            start_idx = 0;
        end
        for (int k = 0; k < N; k++) begin
            idx = (start_idx + k) % N;
            if (!any_o && req_i[idx]) begin
                any_o    = 1'b1;
                winner_o = SEL_W'(idx);
            end
        end
    end

    // One-hot grant decoded from the winner index.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant_o[gi] = any_o && (winner_o == SEL_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/arb_mux_reg.sv
// N-way arbitrating multiplexer with a registered output word. Picks one
// requesting channel per cycle, captures its data, and holds it until the
// consumer accepts it; a new word may replace a draining one in the same edge.
module arb_mux_reg
    import arb_mux_reg_pkg::*;
#(
    parameter int N    = 4,
    parameter int W    = 32,
    parameter int MODE = 1
) (
    input logic          clk,
    input logic          rst,
    arb_mux_reg_if.master bus
);

    localparam int SEL_W = clog2_min1(N);

    logic [W-1:0]     ch_data [N];
    logic [N-1:0]     sel_mask;
    logic [N-1:0]     req;
    logic [N-1:0]     grant;
    logic [SEL_W-1:0] winner;
    logic             any_grant;
    logic             load_en;
    logic [N-1:0]     in_ready;
    logic             chan_hs;

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;
    logic [SEL_W-1:0] ptr_q,       ptr_d;

    // Unpack the flattened channel bus and decode the last-granted channel
    // so lock can restrict arbitration to it.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_chan
            assign ch_data[gi]  = bus.in_data[gi*W +: W];
            assign sel_mask[gi] = (out_sel_q == SEL_W'(gi));
        end
    endgenerate

    assign req = bus.in_valid & (bus.lock ? sel_mask : {N{1'b1}});

    rr_arbiter #(
        .N     (N),
        .SEL_W (SEL_W)
    ) u_arb (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .mode_rr_i (MODE == ARB_RR),
        .grant_o   (grant),
        .winner_o  (winner),
        .any_o     (any_grant)
    );

    // The register can take a word when empty or being drained this cycle.
    assign load_en  = !out_valid_q || bus.out_ready;
    assign in_ready = (load_en && !rst) ? grant : '0;
    // A grant is only issued to a valid requester, so any ready bit is a handshake.
    assign chan_hs  = |in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;

    // Next-state: load on a channel handshake, otherwise clear after a drain.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (chan_hs && any_grant) begin
            out_valid_d = 1'b1;
            out_data_d  = ch_data[winner];
            out_sel_d   = winner;
            if (!bus.lock) begin
                ptr_d = (winner == SEL_W'(N - 1)) ? '0 : winner + SEL_W'(1);
            end
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // State register; reset discards any held word without a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: round-robin, fixed-priority and
// single-channel instances driven through a linear sequence of steps.
module tb_arb_mux_reg;

    logic clk;
    logic rst_rr;
    logic rst_fx;

    int total = 0;
    int bad   = 0;

    int hs_rr [4];
    int hs_fx [4];

    arb_mux_reg_if #(.N(4), .W(32)) if_rr ();
    arb_mux_reg_if #(.N(4), .W(32)) if_fx ();
    arb_mux_reg_if #(.N(1), .W(8))  if_one ();

    arb_mux_reg #(.N(4), .W(32), .MODE(1)) dut_rr (
        .clk (clk),
        .rst (rst_rr),
        .bus (if_rr)
    );

    arb_mux_reg #(.N(4), .W(32), .MODE(0)) dut_fx (
        .clk (clk),
        .rst (rst_fx),
        .bus (if_fx)
    );

    arb_mux_reg #(.N(1), .W(8), .MODE(1)) dut_one (
        .clk (clk),
        .rst (rst_fx),
        .bus (if_one)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 4; i++) begin
            hs_rr[i] = 0;
            hs_fx[i] = 0;
        end
    end

    // Record every channel handshake seen at a clock edge.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (if_rr.in_valid[i] && if_rr.in_ready[i]) hs_rr[i] <= hs_rr[i] + 1;
            if (if_fx.in_valid[i] && if_fx.in_ready[i]) hs_fx[i] <= hs_fx[i] + 1;
        end
    end

    function automatic logic [31:0] dval(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    int exp_sel [6] = '{0, 1, 2, 3, 0, 1};
    int hs_sum_before;

    initial begin
        rst_rr = 1'b1;
        rst_fx = 1'b1;
        if_rr.in_valid  = 4'b1111;
        if_rr.in_data   = {dval(3), dval(2), dval(1), dval(0)};
        if_rr.out_ready = 1'b1;
        if_rr.lock      = 1'b0;
        if_fx.in_valid  = 4'b0000;
        if_fx.in_data   = {dval(3), dval(2), dval(1), dval(0)};
        if_fx.out_ready = 1'b1;
        if_fx.lock      = 1'b0;
        if_one.in_valid  = 1'b0;
        if_one.in_data   = 8'h00;
        if_one.out_ready = 1'b1;
        if_one.lock      = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_in_ready", 64'(if_rr.in_ready), 64'h0);
        chk("rst_out_valid", 64'(if_rr.out_valid), 64'h0);
        chk("rst_out_sel", 64'(if_rr.out_sel), 64'h0);
        chk("rst_out_data", 64'(if_rr.out_data), 64'h0);

        // First grant after release goes to channel 0 (pointer 0)
        rst_rr = 1'b0;
        #1;
        chk("first_grant", 64'(if_rr.in_ready), 64'h1);

        // Round-robin rotation, one word per cycle
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("rr_valid", 64'(if_rr.out_valid), 64'h1);
            chk("rr_sel", 64'(if_rr.out_sel), 64'(exp_sel[k]));
            chk("rr_data", 64'(if_rr.out_data), 64'(dval(exp_sel[k])));
        end

        // Backpressure: hold word from channel 1, no grants
        if_rr.out_ready = 1'b0;
        #1;
        chk("bp_in_ready", 64'(if_rr.in_ready), 64'h0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_valid", 64'(if_rr.out_valid), 64'h1);
            chk("bp_sel", 64'(if_rr.out_sel), 64'h1);
            chk("bp_data", 64'(if_rr.out_data), 64'(dval(1)));
            chk("bp_in_ready_hold", 64'(if_rr.in_ready), 64'h0);
        end
        if_rr.out_ready = 1'b1;
        #1;
        chk("bp_ptr_kept", 64'(if_rr.in_ready), 64'h4);
        tick();
        chk("bp_reload_valid", 64'(if_rr.out_valid), 64'h1);
        chk("bp_reload_sel", 64'(if_rr.out_sel), 64'h2);

        // Lock on channel 2 while it is not requesting: stall
        if_rr.lock     = 1'b1;
        if_rr.in_valid = 4'b1011;
        #1;
        chk("lock_stall_ready", 64'(if_rr.in_ready), 64'h0);
        tick();
        chk("lock_drained", 64'(if_rr.out_valid), 64'h0);
        chk("lock_sel_held", 64'(if_rr.out_sel), 64'h2);
        chk("lock_stall_ready2", 64'(if_rr.in_ready), 64'h0);
        tick();
        chk("lock_stall_ready3", 64'(if_rr.in_ready), 64'h0);
        if_rr.in_data[2*32 +: 32] = 32'h5555_2222;
        if_rr.in_valid = 4'b1111;
        #1;
        chk("lock_grant2", 64'(if_rr.in_ready), 64'h4);
        tick();
        chk("lock_sel", 64'(if_rr.out_sel), 64'h2);
        chk("lock_data", 64'(if_rr.out_data), 64'h5555_2222);
        chk("lock_valid", 64'(if_rr.out_valid), 64'h1);

        // Unlock: resume from pointer 3, then wrap to 0
        if_rr.lock = 1'b0;
        #1;
        chk("unlock_ready", 64'(if_rr.in_ready), 64'h8);
        tick();
        chk("unlock_sel", 64'(if_rr.out_sel), 64'h3);
        chk("wrap_ready", 64'(if_rr.in_ready), 64'h1);

        // Reset while a word is held under backpressure
        if_rr.out_ready = 1'b0;
        tick();
        chk("pre_rst_valid", 64'(if_rr.out_valid), 64'h1);
        chk("pre_rst_sel", 64'(if_rr.out_sel), 64'h3);
        hs_sum_before = hs_rr[0] + hs_rr[1] + hs_rr[2] + hs_rr[3];
        rst_rr = 1'b1;
        #1;
        chk("midrst_ready", 64'(if_rr.in_ready), 64'h0);
        tick();
        chk("midrst_valid", 64'(if_rr.out_valid), 64'h0);
        chk("midrst_sel", 64'(if_rr.out_sel), 64'h0);
        chk("midrst_data", 64'(if_rr.out_data), 64'h0);
        chk("midrst_no_hs", 64'(hs_rr[0] + hs_rr[1] + hs_rr[2] + hs_rr[3]), 64'(hs_sum_before));
        rst_rr = 1'b0;
        if_rr.out_ready = 1'b1;

        // Fixed priority: channel 1 always beats channel 3
        rst_fx = 1'b0;
        if_fx.in_valid = 4'b1010;
        #1;
        chk("fx_ready", 64'(if_fx.in_ready), 64'h2);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fx_sel", 64'(if_fx.out_sel), 64'h1);
            chk("fx_data", 64'(if_fx.out_data), 64'(dval(1)));
            chk("fx_ready_hold", 64'(if_fx.in_ready), 64'h2);
        end
        chk("fx_hs_ch1", 64'(hs_fx[1]), 64'h4);
        chk("fx_starved_ch3", 64'(hs_fx[3]), 64'h0);

        // Single-channel instance
        if_one.in_valid = 1'b1;
        if_one.in_data  = 8'h5A;
        #1;
        chk("one_ready", 64'(if_one.in_ready), 64'h1);
        tick();
        chk("one_valid", 64'(if_one.out_valid), 64'h1);
        chk("one_sel", 64'(if_one.out_sel), 64'h0);
        chk("one_data", 64'(if_one.out_data), 64'h5A);
        if_one.in_valid = 1'b0;
        #1;
        chk("one_idle_ready", 64'(if_one.in_ready), 64'h0);
        tick();
        chk("one_drained", 64'(if_one.out_valid), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/arb_mux_reg.md
Name: arb_mux_reg

Overview:
- Parametrised N-way arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel.
- Successor to the fixed 4:1 combinational select used in the datapath. It picks one of N requesting channels itself instead of taking an external select, then holds the chosen word in an output register until the consumer accepts it.
- Sits between multiple request sources (e.g. instruction-fetch, load/store, and uncached paths) and a single SRAM-side port.

Parameters:
- N, 4, number of input channels (N >= 1)
- W, 32, data width per channel in bits
- MODE, 1, arbitration policy: 0 = fixed priority (channel 0 highest), 1 = round-robin
- SEL_W, derived, index width = max(1, clog2(N)); localparam, not overridable

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  N  per-channel request valid
- in_data  in  N*W  flattened channel data; channel i occupies bits [i*W +: W]
- in_ready  out  N  per-channel accept; at most one bit set per cycle
- out_valid  out  1  output register holds a valid word
- out_data  out  W  registered selected data
- out_sel  out  SEL_W  index of the channel that supplied out_data
- out_ready  in  1  consumer accepts out_data this cycle
- lock  in  1  when high, only the last-granted channel may win; others wait

Behaviour:
- Reset: one clock with rst=1 forces out_valid=0, out_data=0, out_sel=0, rr pointer=0. in_ready is combinational and is 0 whenever rst=1.
- Reset mid-transfer: the word held in the output register is discarded, with no handshake on either side.
- load_en = !out_valid || out_ready. The output register can accept a new word this cycle when it is empty or being drained.
- Grant (combinational): among the set in_valid bits, pick a winner:
  - MODE=0: lowest index wins.
  - MODE=1: first set bit searching upward from the rr pointer, wrapping from N-1 to 0.
- in_ready[i] = load_en && grant[i] && !rst. The handshake on channel i is in_valid[i] && in_ready[i].
- On a channel handshake: out_data <= in_data[winner], out_sel <= winner, out_valid <= 1 at the next edge. Input-to-output latency is 1 cycle.
- On an output drain (out_valid && out_ready) with no new channel handshake: out_valid <= 0; out_data and out_sel hold their values.
- Simultaneous drain and load: the new word replaces the old one in the same edge. Sustained throughput is 1 word/cycle.
- out_valid=1 && out_ready=0: register holds; all in_ready=0; the rr pointer does not move.
- Round-robin pointer update: only on a channel handshake, set to (winner+1) mod N. This wraps from N-1 to 0.
- lock=1: the grant is masked to the channel in out_sel.
  - If that channel is not valid, no grant is issued and the arbiter stalls.
  - The rr pointer does not advance while lock=1.
  - lock is sampled combinationally each cycle.
- No in_valid set: no grant, all in_ready=0, and out_valid clears after a drain.
- N=1: grant = in_valid[0]. SEL_W=1 and out_sel is always 0.
- in_data of a non-granted channel is never sampled. Sources must hold data stable while in_valid=1 and in_ready=0.

Decomposition:
- Shared package holds:
  - MODE constants ARB_FIXED=0 and ARB_RR=1
  - a clog2 helper function used for SEL_W
- One natural sub-module: rr_arbiter.
  - Combinational; inputs are the request vector, the pointer, and mode.
  - Outputs are a one-hot grant and the encoded winner index.
- The top level owns the output register, the rr pointer, and the lock masking.

Test Plan:
- Reset with in_valid=4'b1111 and out_ready=1, release rst -> in_ready=0 during reset. In the first cycle after release: in_ready=4'b0001 (MODE=1, pointer 0), then out_valid=1 with out_sel=0 one cycle later.
- MODE=1, all four channels valid continuously, out_ready=1 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles, one word per cycle, out_data matching each channel's in_data.
- MODE=0, in_valid=4'b1010 held -> channel 1 always wins; channel 3 never gets in_ready (starvation is expected).
- Backpressure: out_ready=0 for 3 cycles while out_valid=1 -> out_data and out_sel stable, in_ready=0000, rr pointer unchanged. Re-asserting out_ready gives a drain and a load in the same cycle.
- lock=1 after a grant to channel 2, with in_valid=4'b1011 -> no grant and a stall. Asserting in_valid[2] gives a grant to channel 2 only. Dropping lock resumes round-robin from pointer 3.
- rst asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_sel=0, and no handshake is recorded on any channel.
